fmap_streamer: RTL and testbench

- Transmit-side source for the Toeplitz matrix generator (tmgall).
- Holds one FMAP_H x FMAP_W feature map in an internal register buffer, loaded through a simple write port.
- On start, streams the map in raster order, one pixel per accepted beat on a valid/ready interface, with an optional zero-padding border.
- Replaces hand-driven fmap stimulus with a real producer feeding the 8-bit fmap input.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/fmap_pad_addr.sv | 29 ++
 rtl/fmap_streamer.sv | 170 +++++++++++++++++
 tb/tb_fmap_streamer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN datapath blocks.
package cnn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDone
    } state_e;

    localparam int DATA_W_DEF = 8;

    // Bit width needed to count 0..v-1. The result is never below 1, so that
    // single-entry ranges still get a legal vector.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fmap_pad_addr.sv
// Maps a padded-map coordinate (r,c) to a border flag and a raster buffer index.
module fmap_pad_addr #(
    parameter int FMAP_H = 3,
    parameter int FMAP_W = 3,
    parameter int PAD    = 0,
    parameter int AW     = 4,
    parameter int RW     = 2,
    parameter int CW     = 2
) (
    input  logic [RW-1:0] r,
    input  logic [CW-1:0] c,
    output logic          is_pad,
    output logic [AW-1:0] idx
);

    int ri;
    int ci;

    always_comb begin
        ri     = int'(r);
        ci     = int'(c);
        is_pad = (ri < PAD) || (ri >= FMAP_H + PAD) || (ci < PAD) || (ci >= FMAP_W + PAD);
        idx    = '0;
        if (!is_pad) begin
            idx = AW'((ri - PAD) * FMAP_W + (ci - PAD));
        end
    end

endmodule

// File: rtl/fmap_streamer.sv
// Feature-map source: buffers one map, then streams it in raster order with an
// optional zero border over a valid/ready interface.
module fmap_streamer
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FMAP_H = 3,
    parameter int FMAP_W = 3,
    parameter int PAD    = 0,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic [DATA_W-1:0] fmap,
    output logic              fmap_valid,
    input  logic              fmap_ready,
    output logic              row_last,
    output logic              fmap_last,
    output logic              busy,
    output logic              done
);

    localparam int OH   = FMAP_H + 2 * PAD;
    localparam int OW   = FMAP_W + 2 * PAD;
    localparam int NPIX = FMAP_H * FMAP_W;
    localparam int RW   = clog2(OH);
    localparam int CW   = clog2(OW);

    state_e            state_q, state_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic [DATA_W-1:0] fmap_q, fmap_d;
    logic              valid_q, valid_d;
    logic              row_last_q, row_last_d;
    logic              fmap_last_q, fmap_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] mem_q [NPIX];

    logic              wr_ok;
    logic              load;
    logic              finish;
    logic              pix_pad;
    logic [AW-1:0]     pix_idx;
    logic [DATA_W-1:0] pix_val;

    assign wr_ok = wr_en && (state_q == StIdle) && (int'(wr_addr) < NPIX);

    // Buffer is deliberately not reset so a map survives an aborted stream.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    fmap_pad_addr #(
        .FMAP_H(FMAP_H),
        .FMAP_W(FMAP_W),
        .PAD   (PAD),
        .AW    (AW),
        .RW    (RW),
        .CW    (CW)
    ) u_pad_addr (
        .r     (r_d),
        .c     (c_d),
        .is_pad(pix_pad),
        .idx   (pix_idx)
    );

    // Forward a same-cycle write so write+start shows the new pixel at once.
    assign pix_val = (wr_ok && (wr_addr == pix_idx)) ? wr_data : mem_q[pix_idx];

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStream;
                    r_d     = '0;
                    c_d     = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            StStream: begin
                if (valid_q && fmap_ready) begin
                    if (fmap_last_q) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        finish  = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (c_q == CW'(OW - 1)) begin
                            c_d = '0;
                            r_d = r_q + RW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        fmap_d      = fmap_q;
        row_last_d  = row_last_q;
        fmap_last_d = fmap_last_q;
        if (load) begin
            fmap_d      = pix_pad ? '0 : pix_val;
            row_last_d  = (c_d == CW'(OW - 1));
            fmap_last_d = (c_d == CW'(OW - 1)) && (r_d == RW'(OH - 1));
        end else if (finish) begin
            fmap_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            r_q         <= '0;
            c_q         <= '0;
            fmap_q      <= '0;
            valid_q     <= 1'b0;
            row_last_q  <= 1'b0;
            fmap_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            fmap_q      <= fmap_d;
            valid_q     <= valid_d;
            row_last_q  <= row_last_d;
            fmap_last_q <= fmap_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign fmap       = fmap_q;
    assign fmap_valid = valid_q;
    assign row_last   = row_last_q;
    assign fmap_last  = fmap_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fmap_streamer.sv
// Scoreboard bench: an unpadded and a one-pixel-padded streamer share stimulus.
module tb_fmap_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic       ready = 1'b1;

    logic [7:0] f0, f1;
    logic       v0, v1, rl0, rl1, fl0, fl1, b0, b1, d0, d1;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_mem [9];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic       d0_prev = 1'b0;
    logic       d1_prev = 1'b0;

    always #5 clk = ~clk;

    fmap_streamer #(.DATA_W(8), .FMAP_H(3), .FMAP_W(3), .PAD(0), .AW(4)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .fmap(f0), .fmap_valid(v0), .fmap_ready(ready),
        .row_last(rl0), .fmap_last(fl0), .busy(b0), .done(d0)
    );

    fmap_streamer #(.DATA_W(8), .FMAP_H(3), .FMAP_W(3), .PAD(1), .AW(4)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .fmap(f1), .fmap_valid(v1), .fmap_ready(ready),
        .row_last(rl1), .fmap_last(fl1), .busy(b1), .done(d1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected beat {row_last, fmap_last, pixel} for a padded coordinate.
    function automatic logic [9:0] exp_beat(input int pad, input int r, input int c);
        int oh, ow;
        logic [7:0] pix;
        oh = 3 + 2 * pad;
        ow = 3 + 2 * pad;
        if (r < pad || r >= 3 + pad || c < pad || c >= 3 + pad) pix = 8'h00;
        else pix = exp_mem[(r - pad) * 3 + (c - pad)];
        return {(c == ow - 1), (r == oh - 1 && c == ow - 1), pix};
    endfunction

    task automatic push_all();
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) q0.push_back(exp_beat(0, r, c));
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) q1.push_back(exp_beat(1, r, c));
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (a < 4'd9) exp_mem[a] = d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((b0 || b1 || d0 || d1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", (n < 200), 1);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
    endtask

    task automatic run_stream(input bit stall, input bit midwr, input bit midrst,
                              input bit wrstart, input int exp_cycles);
        int cycles;
        bit stalled;
        cycles = 0;
        stalled = 0;
        @(posedge clk); #1;
        if (wrstart) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h11;
            exp_mem[0] = 8'h11;
        end
        push_all();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        check("first_valid", v0, 1);
        check("first_busy", b0, 1);
        while (!d0 && cycles < 200) begin
            if (stall && !stalled && v0 && f0 == 8'd5) begin
                ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    cycles++;
                    check("bp_hold_pix", f0, 8'd5);
                    check("bp_hold_valid", v0, 1);
                end
                ready = 1'b1;
                stalled = 1;
            end else if (midrst && v0 && f0 == 8'd5) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_valid0", v0, 0);
                check("rst_busy0", b0, 0);
                check("rst_fmap0", f0, 0);
                check("rst_last0", {rl0, fl0, d0}, 0);
                check("rst_valid1", v1, 0);
                check("rst_busy1", b1, 0);
                q0.delete();
                q1.delete();
                return;
            end else begin
                if (midwr && cycles == 3) begin
                    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hAA; start = 1'b1;
                end
                @(posedge clk); #1;
                cycles++;
                wr_en = 1'b0;
                start = 1'b0;
            end
        end
        check("stream_cycles", cycles, exp_cycles);
        wait_idle();
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && v0 && ready) begin
            if (q0.size() == 0) check("d0_extra_beat", 1, 0);
            else begin
                e = q0.pop_front();
                check("d0_pix", f0, e[7:0]);
                check("d0_row_last", rl0, e[9]);
                check("d0_fmap_last", fl0, e[8]);
            end
        end
        if (!rst && v1 && ready) begin
            if (q1.size() == 0) check("d1_extra_beat", 1, 0);
            else begin
                e = q1.pop_front();
                check("d1_pix", f1, e[7:0]);
                check("d1_row_last", rl1, e[9]);
                check("d1_fmap_last", fl1, e[8]);
            end
        end
        if (d0) begin
            check("d0_done_drained", q0.size(), 0);
            check("d0_done_busy", b0, 0);
            check("d0_done_pulse", d0_prev, 0);
        end
        if (d1) begin
            check("d1_done_drained", q1.size(), 0);
            check("d1_done_busy", b1, 0);
            check("d1_done_pulse", d1_prev, 0);
        end
        d0_prev <= d0;
        d1_prev <= d1;
    end

    initial begin
        for (int i = 0; i < 9; i++) exp_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid0", v0, 0);
        check("reset_fmap0", f0, 0);
        check("reset_flags0", {rl0, fl0, b0, d0}, 0);
        check("reset_valid1", v1, 0);
        check("reset_flags1", {rl1, fl1, b1, d1}, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) write(4'(i), 8'(i + 1));

        run_stream(0, 0, 0, 0, 9);   // plain stream, both geometries
        run_stream(1, 0, 0, 0, 12);  // three-cycle stall on pixel 5
        run_stream(0, 1, 0, 0, 9);   // write+start while streaming are ignored
        run_stream(0, 0, 0, 0, 9);   // map still starts with 1

        write(4'd9, 8'h77);          // out of range, dropped
        write(4'd15, 8'h66);
        run_stream(0, 0, 0, 0, 9);

        run_stream(0, 0, 1, 0, 0);   // reset after four beats
        wait_idle();
        run_stream(0, 0, 0, 0, 9);   // retained buffer replays

        run_stream(0, 0, 0, 1, 9);   // write lands in the same cycle as start
        write(4'd0, 8'd1);
        run_stream(0, 0, 0, 0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
